// File: rtl/decoder_2_4_hold.sv
// Registered 2-to-4 decoder that holds its one-hot output for HOLD_CYCLES cycles per accepted code.
// Optional input parity check is enabled with `define DECODER_PARITY_EN.
module decoder_2_4_hold #(
   parameter int HOLD_CYCLES = 4,
   parameter int CNT_W       = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [1:0] in_code,
`ifdef DECODER_PARITY_EN
   input  logic       in_par,
   output logic       par_err,
`endif
   output logic [3:0] y,
   output logic       y_valid,
   output logic       busy
);

   localparam logic [CNT_W-1:0] RELOAD = CNT_W'(HOLD_CYCLES - 1);

   typedef enum logic {IDLE, HOLD} state_t;

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic             accept;
   logic             par_ok;

   // Ready in the final hold cycle as well, so back-to-back codes see no zero gap.
   assign in_ready = (state == IDLE) || (cnt == '0);
   assign accept   = in_valid && in_ready;

`ifdef DECODER_PARITY_EN
   assign par_ok = ^{in_par, in_code};
`else
   assign par_ok = 1'b1;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         cnt     <= '0;
         y       <= 4'b0000;
         y_valid <= 1'b0;
         busy    <= 1'b0;
`ifdef DECODER_PARITY_EN
         par_err <= 1'b0;
`endif
      end else begin
`ifdef DECODER_PARITY_EN
         par_err <= 1'b0;
`endif
         if (accept) begin
            if (par_ok) begin
               state   <= HOLD;
               cnt     <= RELOAD;
               y       <= 4'b0001 << in_code;
               y_valid <= 1'b1;
               busy    <= 1'b1;
            end else begin
               // Bad parity: the code is consumed but never decoded.
               state   <= IDLE;
               cnt     <= '0;
               y       <= 4'b0000;
               y_valid <= 1'b0;
               busy    <= 1'b0;
`ifdef DECODER_PARITY_EN
               par_err <= 1'b1;
`endif
            end
         end else if (state == HOLD) begin
            if (cnt == '0) begin
               state   <= IDLE;
               y       <= 4'b0000;
               y_valid <= 1'b0;
               busy    <= 1'b0;
            end else begin
               cnt <= cnt - CNT_W'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_decoder_2_4_hold.sv
// Scoreboard bench for decoder_2_4_hold: one instance with HOLD_CYCLES=4, one with HOLD_CYCLES=1.
// Drivers push expected {y, in_ready} per hold cycle; a negedge monitor pops and compares.
module tb_decoder_2_4_hold;

   typedef struct packed {
      logic [3:0] y;
      logic       rdy;
   } exp_t;

   logic            clk;
   logic            rst_n;
   logic [1:0]      v;
   logic [1:0][1:0] c;
   logic [1:0]      p;
   logic [1:0]      rdy;
   logic [1:0][3:0] y;
   logic [1:0]      yv;
   logic [1:0]      bz;
   logic [1:0]      perr;

   exp_t q0[$];
   exp_t q1[$];
   int   total;
   int   bad;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   decoder_2_4_hold #(.HOLD_CYCLES(4), .CNT_W(8)) dut4 (
      .clk(clk), .rst_n(rst_n), .in_valid(v[0]), .in_ready(rdy[0]), .in_code(c[0]),
`ifdef DECODER_PARITY_EN
      .in_par(p[0]), .par_err(perr[0]),
`endif
      .y(y[0]), .y_valid(yv[0]), .busy(bz[0])
   );

   decoder_2_4_hold #(.HOLD_CYCLES(1), .CNT_W(8)) dut1 (
      .clk(clk), .rst_n(rst_n), .in_valid(v[1]), .in_ready(rdy[1]), .in_code(c[1]),
`ifdef DECODER_PARITY_EN
      .in_par(p[1]), .par_err(perr[1]),
`endif
      .y(y[1]), .y_valid(yv[1]), .busy(bz[1])
   );

`ifndef DECODER_PARITY_EN
   assign perr = 2'b00;
`endif

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic mon(input int d);
      exp_t e;
      logic have;
      have = 1'b0;
      e    = '0;
      if (yv[d]) begin
         if (d == 0 && q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
         if (d == 1 && q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
         if (!have) chk($sformatf("extra_valid%0d", d), {31'd0, yv[d]}, 32'd0);
         else begin
            chk($sformatf("y%0d", d),    {28'd0, y[d]},  {28'd0, e.y});
            chk($sformatf("rdy%0d", d),  {31'd0, rdy[d]}, {31'd0, e.rdy});
            chk($sformatf("busy%0d", d), {31'd0, bz[d]},  32'd1);
         end
      end else begin
         chk($sformatf("idle_y%0d", d),    {28'd0, y[d]},  32'd0);
         chk($sformatf("idle_rdy%0d", d),  {31'd0, rdy[d]}, 32'd1);
         chk($sformatf("idle_busy%0d", d), {31'd0, bz[d]},  32'd0);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         mon(0);
         mon(1);
      end
   end

   // Present a code and hold it until accepted; good=1 means it should be decoded.
   task automatic send(input int d, input logic [1:0] code, input logic par, input logic good);
      logic ok;
      logic r;
      int   hc;
      exp_t e;
      hc   = (d == 0) ? 4 : 1;
      v[d] = 1'b1;
      c[d] = code;
      p[d] = par;
      ok   = 1'b0;
      for (int i = 0; i < 64 && !ok; i++) begin
         @(negedge clk);
         r = rdy[d];
         @(posedge clk);
         ok = r;
      end
      if (!ok) chk("accept_timeout", 32'd0, 32'd1);
      else if (good) begin
         for (int k = 0; k < hc; k++) begin
            e.y   = 4'b0001 << code;
            e.rdy = (k == hc - 1);
            if (d == 0) q0.push_back(e);
            else        q1.push_back(e);
         end
      end
      #1;
   endtask

   task automatic drain(input string name);
      chk({name, "_q0"}, q0.size(), 32'd0);
      chk({name, "_q1"}, q1.size(), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      total = 0;
      bad   = 0;
      rst_n = 1'b0;
      v     = '0;
      c     = '0;
      p     = '0;

      // Test 1: reset, then idle
      repeat (3) @(posedge clk);
      #1;
      chk("rst_y",    {28'd0, y[0]},  32'd0);
      chk("rst_yv",   {31'd0, yv[0]}, 32'd0);
      chk("rst_busy", {31'd0, bz[0]}, 32'd0);
      chk("rst_rdy",  {30'd0, rdy},   32'd3);
      rst_n = 1'b1;
      repeat (4) @(posedge clk);
      #1;

      // Test 2: single decode of 10, held 4 cycles
      send(0, 2'b10, 1'b0, 1'b1);
      v[0] = 1'b0;
      repeat (6) @(posedge clk);
      #1;
      drain("single");

      // Test 3: back-to-back 01 then 11 with in_valid held high
      send(0, 2'b01, 1'b0, 1'b1);
      send(0, 2'b11, 1'b1, 1'b1);
      v[0] = 1'b0;
      repeat (6) @(posedge clk);
      #1;
      drain("b2b");

      // Test 4: HOLD_CYCLES=1, every code at full throughput
      send(1, 2'b00, 1'b1, 1'b1);
      send(1, 2'b01, 1'b0, 1'b1);
      send(1, 2'b10, 1'b0, 1'b1);
      send(1, 2'b11, 1'b1, 1'b1);
      v[1] = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      drain("thru");

      // Test 5: reset asserted in the second hold cycle
      send(0, 2'b11, 1'b1, 1'b1);
      v[0] = 1'b0;
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("midrst_y",    {28'd0, y[0]},   32'd0);
      chk("midrst_yv",   {31'd0, yv[0]},  32'd0);
      chk("midrst_busy", {31'd0, bz[0]},  32'd0);
      chk("midrst_rdy",  {31'd0, rdy[0]}, 32'd1);
      q0.delete();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      drain("midrst");

`ifdef DECODER_PARITY_EN
      // Test 6: parity good then parity bad on code 01
      send(0, 2'b01, 1'b0, 1'b1);
      v[0] = 1'b0;
      @(negedge clk);
      chk("par_ok_err", {31'd0, perr[0]}, 32'd0);
      repeat (5) @(posedge clk);
      #1;
      drain("par_ok");
      send(0, 2'b01, 1'b1, 1'b0);
      v[0] = 1'b0;
      @(negedge clk);
      chk("par_bad_err", {31'd0, perr[0]}, 32'd1);
      chk("par_bad_rdy", {31'd0, rdy[0]},  32'd1);
      @(negedge clk);
      chk("par_bad_pulse", {31'd0, perr[0]}, 32'd0);
      repeat (3) @(posedge clk);
      #1;
      drain("par_bad");
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/decoder_2_4_hold.md
Name: decoder_2_4_hold

Overview:
- Registered 2-to-4 decoder, the inverse of the team's 4-to-2 priority encoder.
- Accepts a 2-bit index through a valid/ready handshake and drives the matching one-hot 4-bit output.
- Holds that output for a programmable number of cycles, then releases it.
- Sits downstream of encoder-produced indices to regenerate one-hot select/grant lines for a fixed dwell time.

Parameters:
- HOLD_CYCLES, 4: number of cycles y stays one-hot per accepted code; legal range 1..2**CNT_W.
- CNT_W, 8: hold counter width in bits.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  in_code is valid this cycle.
- in_ready  output  1  block can accept a code this cycle.
- in_code  input  2  index to decode; bit 1 is MSB.
- y  output  4  registered one-hot output; all-zero when idle.
- y_valid  output  1  y currently holds a decoded value.
- busy  output  1  state is HOLD.

Behaviour:
- Interface (already decided): one clock, clk. Reset rst_n is asynchronous and active-low. Assertion clears all state immediately, with no clock required. Deassertion is sampled on the clk rising edge.
- Reset values: state=IDLE, y=4'b0000, y_valid=0, busy=0, counter=0. in_ready=1 while in reset, because it is combinational from state.
- States:
  - IDLE: in_ready=1, y=0, y_valid=0.
  - HOLD: y=1<<code_q, y_valid=1, busy=1.
- Accept occurs when in_valid && in_ready at a rising edge.
  - in_code is captured into code_q.
  - counter is loaded with HOLD_CYCLES-1.
  - state goes to HOLD.
- Latency: y becomes one-hot on the first edge after accept, i.e. 1-cycle registered latency.
- Mapping: 00->0001, 01->0010, 10->0100, 11->1000. y never has more than one bit set.
- HOLD behaviour:
  - counter decrements by 1 each cycle.
  - in_ready=0 while counter!=0.
  - in_ready=1 in the final hold cycle, when counter==0.
- Final hold cycle, no accept: next state is IDLE, y=0 and y_valid=0 on the next cycle. Total hold is exactly HOLD_CYCLES cycles.
- Final hold cycle with accept (back-to-back):
  - Counter reloads and state stays HOLD.
  - y switches directly to the new one-hot with no zero gap.
  - y_valid stays 1.
- HOLD_CYCLES=1: counter is loaded with 0, so every HOLD cycle is a final cycle. A continuously asserted in_valid yields a new decode every cycle at full throughput.
- in_valid while in_ready=0: ignored. The code is not captured and y is unchanged. The source must hold in_valid and in_code until accepted.
- in_code changes while held are irrelevant; only the captured code_q drives y.
- Reset mid-HOLD: y, y_valid and busy clear asynchronously. After release the block returns to IDLE with no residual hold.
- Counter arithmetic is unsigned, CNT_W bits. HOLD_CYCLES-1 must fit in CNT_W bits; violating this is illegal and not checked.

Optional Feature:
- Macro DECODER_PARITY_EN.
- Defined:
  - Adds input in_par (1 bit) and output par_err (1 bit).
  - At accept, odd parity is checked over {in_par, in_code}.
  - On mismatch, the transaction is still consumed (handshake completes) but state stays IDLE and y stays 0.
  - par_err pulses 1 for exactly one cycle, on the edge after accept.
  - par_err resets to 0.
- Not defined: in_par and par_err do not exist, and every accepted code is decoded.

Test Plan:
1. Reset then idle: assert rst_n=0 for 3 cycles, release, no in_valid -> y=0000, y_valid=0, busy=0, in_ready=1 throughout.
2. Single decode, HOLD_CYCLES=4: in_code=2'b10 for one accepted cycle -> next cycle y=0100, y_valid=1 for exactly 4 cycles, then y=0000; in_ready=0 for the first 3 hold cycles and 1 in the 4th.
3. Back-to-back: in_valid held high with code 01, then 11 presented in the final hold cycle -> y=0010 for 4 cycles, then immediately y=1000 for 4 cycles, with y_valid never dropping.
4. All codes with HOLD_CYCLES=1, in_valid continuous: codes 00,01,10,11 -> y=0001,0010,0100,1000 on consecutive cycles, each exactly 1 cycle, one cycle after presentation.
5. Reset mid-hold: accept 11, assert rst_n=0 during the 2nd hold cycle -> y=0000 and busy=0 without a clock edge; after release, y stays 0000 until a new accept.
6. DECODER_PARITY_EN defined:
   - in_code=01, in_par=0 (odd parity) -> y=0010, par_err=0.
   - in_code=01, in_par=1 -> y stays 0000, par_err=1 for one cycle, in_ready=1 next cycle.
